// File: rtl/vector_magnitude_pkg.sv
// vector_magnitude_pkg: shared FSM state type and width helpers for the magnitude tile.
//   sum_w(w): width of x^2+y^2+z^2 for w-bit operands
//   res_w(w): width of the magnitude result
package vector_magnitude_pkg;
    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
    function automatic int sum_w(input int w);
        return 2 * w + 2;
    endfunction
    function automatic int res_w(input int w);
        return w + 1;
    endfunction
endpackage

// File: rtl/vector_magnitude_seq_if.sv
// vector_magnitude_seq_if: operand/result handshake bundle of the magnitude block.
//   in_valid/in_ready + in_x/in_y/in_z/in_mode3d : operand request
//   out_valid/out_ready + out_mag/out_exact      : result delivery
//   master drives operands and out_ready; slave (the block) drives the rest
interface vector_magnitude_seq_if #(parameter int WIDTH = 8);
    localparam int RW = vector_magnitude_pkg::res_w(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [WIDTH-1:0] in_z;
    logic             in_mode3d;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_mag;
    logic             out_exact;
    modport master(output in_valid, in_x, in_y, in_z, in_mode3d, out_ready,
                   input in_ready, out_valid, out_mag, out_exact);
    modport slave(input in_valid, in_x, in_y, in_z, in_mode3d, out_ready,
                  output in_ready, out_valid, out_mag, out_exact);
endinterface

// File: rtl/isqrt_seq.sv
// isqrt_seq: restoring digit-by-digit integer square root, one root bit per cycle, MSB first.
//   clk/rst/ena : clock, sync active-high reset, global enable
//   start       : load radicand and begin (SW/2 iterations follow)
//   radicand    : SW-bit unsigned input
//   busy/done   : iterating / one-cycle pulse after the last iteration
//   root/rem    : floor(sqrt(radicand)) and radicand - root^2
module isqrt_seq #(parameter int SW = 18) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            start,
    input  logic [SW-1:0]   radicand,
    output logic            busy,
    output logic            done,
    output logic [SW/2-1:0] root,
    output logic [SW/2:0]   rem
);
    localparam int N  = SW / 2;
    localparam int CW = $clog2(N);
    logic [SW-1:0]  r_rad;
    logic [N-1:0]   r_root;
    logic [N:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [N+2:0]   w_acc;
    logic [N+2:0]   w_trial;
    logic [N+2:0]   w_diff;
    logic           w_ge;
    // Bring down the next radicand digit pair and try appending a 1 to the root.
    assign w_acc   = {r_rem, r_rad[SW-1 -: 2]};
    assign w_trial = {1'b0, r_root, 2'b01};
    assign w_diff  = w_acc - w_trial;
    assign w_ge    = w_acc >= w_trial;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (ena) begin
            if (start) begin
                r_rad  <= radicand;
                r_root <= '0;
                r_rem  <= '0;
                r_cnt  <= CW'(N - 1);
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (r_busy) begin
                r_rad  <= {r_rad[SW-3:0], 2'b00};
                r_root <= {r_root[N-2:0], w_ge};
                // Remainder never exceeds 2*root, so it always fits N+1 bits.
                r_rem  <= (N+1)'(w_ge ? w_diff : w_acc);
                r_cnt  <= r_cnt - 1'b1;
                r_busy <= r_cnt != '0;
                r_done <= r_cnt == '0;
            end else begin
                r_done <= 1'b0;
            end
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;
    assign rem  = r_rem;
endmodule

// File: rtl/vector_magnitude_seq.sv
// vector_magnitude_seq: integer sqrt(x^2+y^2[+z^2]) with handshakes, optional rounding, exactness flag.
//   clk/rst/ena : clock, sync active-high reset, global enable (0 freezes all state)
//   bus         : slave side of vector_magnitude_seq_if (operands in, magnitude out)
module vector_magnitude_seq import vector_magnitude_pkg::*; #(
    parameter int WIDTH = 8,
    parameter bit ROUND = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    vector_magnitude_seq_if.slave  bus
);
    localparam int SW = sum_w(WIDTH);
    localparam int RW = res_w(WIDTH);
    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [RW-1:0]    r_mag;
    logic             r_exact;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [RW-1:0]    w_root;
    logic [RW:0]      w_rem;
    logic [SW-1:0]    w_sum;
    logic             w_up;
    assign w_sum = SW'(r_x) * SW'(r_x) + SW'(r_y) * SW'(r_y) + SW'(r_z) * SW'(r_z);
    // (r+0.5)^2 = r^2 + r + 0.25, so round up exactly when the remainder exceeds r.
    assign w_up  = ROUND && (w_rem > {1'b0, w_root});
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE:    w_next = bus.in_valid ? SQUARE : IDLE;
            SQUARE: begin
                w_start = 1'b1;
                w_next  = ROOT;
            end
            ROOT:    w_next = (w_done && !w_busy) ? DONE : ROOT;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_mag   <= '0;
            r_exact <= 1'b0;
        end else if (ena) begin
            r_state <= w_next;
            if (r_state == IDLE && bus.in_valid) begin
                r_x <= bus.in_x;
                r_y <= bus.in_y;
                r_z <= bus.in_mode3d ? bus.in_z : '0;
            end
            if (r_state == ROOT && w_next == DONE) begin
                r_mag   <= w_root + RW'(w_up);
                r_exact <= w_rem == '0;
            end
        end
    end
    isqrt_seq #(.SW(SW)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .start    (w_start),
        .radicand (w_sum),
        .busy     (w_busy),
        .done     (w_done),
        .root     (w_root),
        .rem      (w_rem)
    );
    assign bus.in_ready  = ena && r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.out_mag   = r_mag;
    assign bus.out_exact = r_exact;
endmodule

// File: tb/tb_vector_magnitude_seq.sv
// tb_vector_magnitude_seq: directed and random checks of both rounding variants side by side.
module tb_vector_magnitude_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       v   = 1'b0;
    logic       rdy = 1'b0;
    logic       m3  = 1'b0;
    logic [7:0] xd  = '0;
    logic [7:0] yd  = '0;
    logic [7:0] zd  = '0;
    int         n_chk = 0;
    int         n_bad = 0;
    always #5 clk = ~clk;
    vector_magnitude_seq_if #(.WIDTH(8)) b0 ();
    vector_magnitude_seq_if #(.WIDTH(8)) b1 ();
    assign b0.in_valid = v;
    assign b1.in_valid = v;
    assign b0.in_x = xd;
    assign b1.in_x = xd;
    assign b0.in_y = yd;
    assign b1.in_y = yd;
    assign b0.in_z = zd;
    assign b1.in_z = zd;
    assign b0.in_mode3d = m3;
    assign b1.in_mode3d = m3;
    assign b0.out_ready = rdy;
    assign b1.out_ready = rdy;
    vector_magnitude_seq #(.WIDTH(8), .ROUND(1'b0)) dut0 (.clk(clk), .rst(rst), .ena(ena), .bus(b0));
    vector_magnitude_seq #(.WIDTH(8), .ROUND(1'b1)) dut1 (.clk(clk), .rst(rst), .ena(ena), .bus(b1));
    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    function automatic int fsqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction
    // Accept one transaction, optionally stall ena / hold out_ready, then check and drain it.
    task automatic xact(input string tag, input int x, input int y, input int z, input bit d3,
                        input int e0, input int ex, input int e1,
                        input int lat, input int stall, input int hold);
        int n = 0;
        xd = 8'(x); yd = 8'(y); zd = 8'(z); m3 = d3; v = 1'b1;
        chk({tag, ".in_ready"}, int'(b0.in_ready), 1);
        @(negedge clk);
        v = 1'b0;
        xd = 8'd99; yd = 8'd77; zd = 8'd55;
        while (!b0.out_valid && n < 60) begin
            if (n == 3 && stall > 0) begin
                ena = 1'b0;
                repeat (stall) @(negedge clk);
                ena = 1'b1;
                n += stall;
            end
            @(negedge clk);
            n++;
        end
        if (lat > 0) chk({tag, ".latency"}, n, lat);
        chk({tag, ".valid"}, int'(b0.out_valid), 1);
        chk({tag, ".mag_floor"}, int'(b0.out_mag), e0);
        chk({tag, ".exact"}, int'(b0.out_exact), ex);
        chk({tag, ".mag_round"}, int'(b1.out_mag), e1);
        chk({tag, ".exact_r"}, int'(b1.out_exact), ex);
        if (hold > 0) begin
            v = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, ".hold_valid"}, int'(b0.out_valid), 1);
                chk({tag, ".hold_mag"}, int'(b0.out_mag), e0);
                chk({tag, ".hold_in_ready"}, int'(b0.in_ready), 0);
            end
            v = 1'b0;
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        chk({tag, ".drained"}, int'(b0.out_valid), 0);
        chk({tag, ".mag_kept"}, int'(b0.out_mag), e0);
    endtask
    initial begin
        int x, y, z, s, r, e1;
        bit d3;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", int'(b0.out_valid), 0);
        chk("rst.out_mag", int'(b0.out_mag), 0);
        chk("rst.out_exact", int'(b0.out_exact), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.in_ready", int'(b0.in_ready), 1);
        xact("p34", 3, 4, 0, 1'b0, 5, 1, 5, 11, 0, 0);
        xact("p255", 255, 255, 0, 1'b0, 360, 0, 361, 11, 0, 0);
        xact("p3d255", 255, 255, 255, 1'b1, 441, 0, 442, 11, 0, 0);
        xact("p122", 1, 2, 2, 1'b1, 3, 1, 3, 11, 0, 0);
        xact("p00", 0, 0, 0, 1'b0, 0, 1, 0, 11, 0, 0);
        xact("zign", 6, 8, 200, 1'b0, 10, 1, 10, 11, 0, 0);
        xact("bkpr", 5, 12, 0, 1'b0, 13, 1, 13, 11, 0, 5);
        xact("stall", 10, 20, 0, 1'b0, 22, 0, 22, 15, 4, 0);
        // Abort a transaction mid-ROOT: nothing may come out afterwards.
        xd = 8'd30; yd = 8'd40; m3 = 1'b0; v = 1'b1;
        @(negedge clk);
        v = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.out_valid", int'(b0.out_valid), 0);
        chk("abort.in_ready", int'(b0.in_ready), 1);
        begin
            int seen = 0;
            repeat (15) begin
                @(negedge clk);
                seen |= int'(b0.out_valid) | int'(b1.out_valid);
            end
            chk("abort.no_result", seen, 0);
        end
        xact("post_abort", 9, 12, 0, 1'b0, 15, 1, 15, 11, 0, 0);
        for (int i = 0; i < 24; i++) begin
            x = int'($urandom_range(255));
            y = int'($urandom_range(255));
            z = int'($urandom_range(255));
            d3 = 1'($urandom_range(1));
            s = x * x + y * y + (d3 ? z * z : 0);
            r = fsqrt(s);
            e1 = (s - r * r > r) ? r + 1 : r;
            xact($sformatf("rnd%0d", i), x, y, z, d3, r, int'(s == r * r), e1, 11, 0, 0);
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
